dram_bit_reader: RTL
====================

// Module: dram_bit_reader
// PURPOSE
//   Read-side sequencer for a 512 x 1-bit distributed select RAM.
//   - Drives the RAM address and samples its asynchronous data output, one bit per cycle.
//   - Packs bits LSB-first into WORD_W-bit words.
//   - Presents each word on a valid/ready stream.
//   - Sits beside the RAM; the write port is owned by another agent.
// PARAMETERS
//   ADDR_W  9   RAM address width (depth = 2**ADDR_W)
//   WORD_W  8   bits packed per output word (1..32)
//   CNT_W   7   width of word-count request
// PORTS
//   CLK         in   1       clock, all flops rise on posedge
//   CLR         in   1       asynchronous active-high reset
//   START       in   1       request pulse; sampled only in IDLE
//   START_ADDR  in   ADDR_W  first bit address of transfer
//   WORD_CNT    in   CNT_W   number of words to read
//   RAM_A       out  ADDR_W  address to RAM A port
//   RAM_O       in   1       RAM asynchronous read data
//   M_VALID     out  1       output word valid
//   M_READY     in   1       downstream accepts word
//   M_DATA      out  WORD_W  packed word, bit0 = lowest address
//   BUSY        out  1       high whenever state != IDLE
//   DONE        out  1       one-cycle pulse on transfer end
// BEHAVIOUR
//   Reset
//     - CLR high, asynchronous: state=IDLE.
//     - RAM_A=0, M_DATA=0, M_VALID=0, BUSY=0, DONE=0.
//     - Bit counter and word counter cleared.
//     - CLR mid-transfer aborts: no DONE pulse, partial word discarded.
//   State IDLE
//     - START=1 and WORD_CNT!=0 -> FETCH; RAM_A<=START_ADDR; words_left<=WORD_CNT.
//     - START=1 and WORD_CNT==0 -> stay IDLE; DONE=1 for next cycle only.
//   State FETCH (exactly WORD_W cycles)
//     - Each posedge: M_DATA[bit_idx]<=RAM_O; RAM_A<=RAM_A+1; bit_idx++.
//     - RAM_A wraps modulo 2**ADDR_W (511 -> 0); no error.
//     - After WORD_W-th sample -> HOLD, M_VALID<=1, words_left--.
//   State HOLD
//     - M_VALID=1; M_DATA stable; RAM_A stable.
//     - M_VALID && M_READY at posedge: M_VALID<=0.
//       - words_left!=0 -> FETCH, bit_idx<=0.
//       - words_left==0 -> IDLE, DONE<=1 for one cycle.
//     - M_READY low: hold indefinitely; M_VALID never drops without handshake.
//   Timing
//     - START at edge 0: first M_VALID visible after edge WORD_W.
//     - Per word throughput: WORD_W+1 cycles at M_READY=1.
//   Boundary rules
//     - START while BUSY ignored; START_ADDR/WORD_CNT captured only at accept.
//     - M_READY while M_VALID=0 ignored.
//     - RAM contents changing mid-transfer: bit sampled at its own edge is used.
// TESTING
//   - Reset: CLR pulse mid-FETCH -> all outputs 0 immediately; no DONE; START next accepted.
//   - Single word: RAM[3..10]=1,0,1,1,0,0,1,0; START_ADDR=3, CNT=1, READY=1
//     -> M_DATA=8'h4D valid after edge 8; DONE pulse after edge 9.
//   - Wrap: RAM[508..511]=1111, RAM[0..3]=0000; START_ADDR=508, CNT=1
//     -> M_DATA=8'h0F; RAM_A ends at 4.
//   - Backpressure: CNT=2, READY low 5 cycles at first word
//     -> M_VALID/M_DATA held steady; second word follows; one DONE.
//   - CNT=0 -> no M_VALID; DONE single pulse; BUSY stays 0.
//   - START asserted during BUSY with different addr -> ignored; output matches first request.

Source files
------------

// File: rtl/dram_bit_reader.sv
// Read-side sequencer for a 512 x 1-bit distributed RAM: walks the address,
// packs the async read bit LSB-first into words and streams them out valid/ready.
module dram_bit_reader #(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [CNT_W-1:0]  WORD_CNT,
  output logic [ADDR_W-1:0] RAM_A,
  input  logic              RAM_O,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [WORD_W-1:0] M_DATA,
  output logic              BUSY,
  output logic              DONE
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t             state;
  state_t             state_next;
  logic [BIT_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   words_left;
  logic               last_bit;

  assign last_bit = (bit_idx == BIT_W'(WORD_W - 1));
  assign BUSY     = (state != IDLE);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START && (WORD_CNT != '0)) state_next = FETCH;
      FETCH:   if (last_bit) state_next = HOLD;
      HOLD:    if (M_VALID && M_READY) state_next = (words_left != '0) ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath; the RAM read is asynchronous, so the bit at RAM_A is captured
  // on the same edge that advances the address.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      RAM_A      <= '0;
      M_DATA     <= '0;
      M_VALID    <= 1'b0;
      DONE       <= 1'b0;
      bit_idx    <= '0;
      words_left <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (WORD_CNT != '0) begin
              RAM_A      <= START_ADDR;
              words_left <= WORD_CNT;
              bit_idx    <= '0;
            end else begin
              DONE <= 1'b1;
            end
          end
        end
        FETCH: begin
          M_DATA[bit_idx] <= RAM_O;
          RAM_A           <= RAM_A + ADDR_W'(1);
          if (last_bit) begin
            M_VALID    <= 1'b1;
            words_left <= words_left - CNT_W'(1);
            bit_idx    <= '0;
          end else begin
            bit_idx <= bit_idx + BIT_W'(1);
          end
        end
        HOLD: begin
          if (M_VALID && M_READY) begin
            M_VALID <= 1'b0;
            bit_idx <= '0;
            if (words_left == '0) DONE <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
